// File: rtl/dt_pkg.sv
// rtl/dt_pkg.sv - shared constants and FSM state type for the distance-transform pack stage
package dt_pkg;

  // Image geometry: 128x128 pixels, packed 16 per word, 8 words per row
  localparam int IMG_DIM       = 128;
  localparam int WORDS_PER_ROW = 8;
  localparam int PIX_PER_WORD  = 16;

  // res_addr = {row[6:0], word[2:0], pix[3:0]}; sti_addr = {row[6:0], word[2:0]}
  localparam int RES_AW = 14;
  localparam int STI_AW = 10;

  // Foreground counter: 15 bits holds every value up to the full image (16384)
  localparam int FG_W   = 15;
  localparam int FG_MAX = IMG_DIM * IMG_DIM;

  typedef enum logic [2:0] {
    ST_LOAD_THR,
    ST_RD,
    ST_LAST,
    ST_WR,
    ST_FIN
  } dt_state_e;

  function automatic logic [4:0] popcount16(input logic [PIX_PER_WORD-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/dt_pack_shreg.sv
// rtl/dt_pack_shreg.sv - threshold compare and MSB-first pixel shift register with popcount
module dt_pack_shreg
  import dt_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    shift_i,
  input  logic [7:0]              data_i,
  input  logic [7:0]              thr_i,
  output logic [PIX_PER_WORD-1:0] word_next_o,
  output logic [4:0]              pop_next_o
);

  logic [PIX_PER_WORD-1:0] shreg_q;
  logic [PIX_PER_WORD-1:0] shreg_d;

  // Shift in one pixel bit per returned read; earliest pixel ends up in bit 15
  always_comb begin
    shreg_d = shreg_q;
    if (shift_i) begin
      shreg_d = {shreg_q[PIX_PER_WORD-2:0], (data_i >= thr_i)};
    end
  end

  // Shift register state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  // The next value is exposed so the final pixel can be written without an extra cycle
  assign word_next_o = shreg_d;
  assign pop_next_o  = popcount16(shreg_d);

endmodule

// File: rtl/dt_pack.sv
// rtl/dt_pack.sv - thresholds the distance map and packs 16 pixels per binary-image word
module dt_pack
  import dt_pkg::*;
#(
  parameter int N_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        thr,
  output logic              res_rd,
  output logic [RES_AW-1:0] res_addr,
  input  logic [7:0]        res_di,
  output logic              sti_wr,
  output logic [STI_AW-1:0] sti_addr,
  output logic [15:0]       sti_do,
  output logic [FG_W-1:0]   fg_cnt,
  output logic              done
);

  localparam logic [STI_AW-1:0] LAST_W   = STI_AW'(N_WORDS - 1);
  localparam logic [FG_W:0]     FG_MAX_V = (FG_W + 1)'(FG_MAX);

  dt_state_e         state_q, state_d;
  logic [7:0]        thr_q, thr_d;
  logic [STI_AW-1:0] w_q, w_d;
  logic              rd_dly_q, rd_dly_d;
  logic              res_rd_q, res_rd_d;
  logic [RES_AW-1:0] res_addr_q, res_addr_d;
  logic              sti_wr_q, sti_wr_d;
  logic [STI_AW-1:0] sti_addr_q, sti_addr_d;
  logic [15:0]       sti_do_q, sti_do_d;
  logic [FG_W-1:0]   fg_q, fg_d;
  logic              done_q, done_d;
  logic [15:0]       word_next;
  logic [4:0]        pop_next;
  logic [FG_W:0]     fg_sum;

  // Read data returns one cycle after each registered address, so shifting follows res_rd by one
  dt_pack_shreg u_shreg (
    .clk_i       (clk),
    .rst_ni      (reset),
    .shift_i     (rd_dly_q),
    .data_i      (res_di),
    .thr_i       (thr_q),
    .word_next_o (word_next),
    .pop_next_o  (pop_next)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_LOAD_THR;
      thr_q      <= '0;
      w_q        <= '0;
      rd_dly_q   <= 1'b0;
      res_rd_q   <= 1'b0;
      res_addr_q <= '0;
      sti_wr_q   <= 1'b0;
      sti_addr_q <= '0;
      sti_do_q   <= '0;
      fg_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      thr_q      <= thr_d;
      w_q        <= w_d;
      rd_dly_q   <= rd_dly_d;
      res_rd_q   <= res_rd_d;
      res_addr_q <= res_addr_d;
      sti_wr_q   <= sti_wr_d;
      sti_addr_q <= sti_addr_d;
      sti_do_q   <= sti_do_d;
      fg_q       <= fg_d;
      done_q     <= done_d;
    end
  end

  // Next-state: 16 reads, one drain cycle, one write, then next word or finish
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD_THR: state_d = ST_RD;
      ST_RD:       if (res_addr_q[3:0] == 4'hF) state_d = ST_LAST;
      ST_LAST:     state_d = ST_WR;
      ST_WR:       state_d = (w_q == LAST_W) ? ST_FIN : ST_RD;
      ST_FIN:      state_d = ST_FIN;
      default:     state_d = ST_LOAD_THR;
    endcase
  end

  // Output next values; strobes follow the upcoming state so they are high during it
  always_comb begin
    thr_d      = thr_q;
    w_d        = w_q;
    res_addr_d = res_addr_q;
    sti_addr_d = sti_addr_q;
    sti_do_d   = sti_do_q;
    fg_d       = fg_q;
    res_rd_d   = (state_d == ST_RD);
    sti_wr_d   = (state_d == ST_WR);
    done_d     = (state_d == ST_FIN);
    rd_dly_d   = res_rd_q;
    fg_sum     = {1'b0, fg_q} + {{(FG_W - 4){1'b0}}, pop_next};
    case (state_q)
      ST_LOAD_THR: begin
        thr_d      = thr;
        w_d        = '0;
        res_addr_d = '0;
      end
      ST_RD: begin
        if (state_d == ST_RD) res_addr_d = res_addr_q + 1'b1;
      end
      ST_LAST: begin
        sti_addr_d = w_q;
        sti_do_d   = word_next;
        fg_d       = (fg_sum > FG_MAX_V) ? FG_MAX_V[FG_W-1:0] : fg_sum[FG_W-1:0];
      end
      ST_WR: begin
        if (state_d == ST_RD) begin
          w_d        = w_q + 1'b1;
          res_addr_d = res_addr_q + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign res_rd   = res_rd_q;
  assign res_addr = res_addr_q;
  assign sti_wr   = sti_wr_q;
  assign sti_addr = sti_addr_q;
  assign sti_do   = sti_do_q;
  assign fg_cnt   = fg_q;
  assign done     = done_q;

endmodule

// File: tb/tb_dt_pack.sv
// tb/tb_dt_pack.sv - scoreboard bench for dt_pack with a behavioural distance-map RAM
module tb_dt_pack;

  localparam int NW       = 1024;
  localparam int DONE_CYC = 1 + 18 * NW;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  thr = 8'd0;
  logic [7:0]  res_di = 8'd0;
  logic        res_rd;
  logic [13:0] res_addr;
  logic        sti_wr;
  logic [9:0]  sti_addr;
  logic [15:0] sti_do;
  logic [14:0] fg_cnt;
  logic        done;

  dt_pack #(.N_WORDS(NW)) dut (
    .clk      (clk),
    .reset    (reset),
    .thr      (thr),
    .res_rd   (res_rd),
    .res_addr (res_addr),
    .res_di   (res_di),
    .sti_wr   (sti_wr),
    .sti_addr (sti_addr),
    .sti_do   (sti_do),
    .fg_cnt   (fg_cnt),
    .done     (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  int mode = 0;

  function automatic logic [7:0] pix_val(input int m, input logic [13:0] a);
    case (m)
      0:       return 8'd0;
      1:       return 8'd5;
      2:       return (a[13:4] == 10'd7 && a[3:0] == 4'd0) ? 8'd3 : 8'd0;
      3:       return a[0] ? 8'd0 : 8'd2;
      default: return 8'd1;
    endcase
  endfunction

  function automatic logic [15:0] exp_word(input int m, input int w, input logic [7:0] t);
    logic [15:0] r;
    logic [9:0]  wa;
    logic [3:0]  k4;
    wa = w[9:0];
    r  = '0;
    for (int k = 0; k < 16; k++) begin
      k4 = k[3:0];
      r[15-k] = (pix_val(m, {wa, k4}) >= t);
    end
    return r;
  endfunction

  // Synchronous-read RAM model: data for a registered address appears one cycle later
  always @(posedge clk) begin
    if (res_rd) res_di <= pix_val(mode, res_addr);
  end

  int cyc = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  logic [25:0] sb_q[$];
  int          wr_cnt = 0;
  int          extra_wr = 0;
  int          fg_exp = 0;
  int          viol = 0;
  int          done_cyc = -1;
  logic        prev_wr = 1'b0;
  logic [9:0]  prev_addr = '0;
  logic [15:0] prev_do = '0;

  // Write monitor and protocol watch
  always @(negedge clk) begin
    logic [25:0] e;
    if (reset) begin
      if (sti_wr) begin
        wr_cnt++;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("wr_addr", 32'(sti_addr), 32'(e[25:16]));
          chk("wr_data", 32'(sti_do), 32'(e[15:0]));
          fg_exp += $countones(e[15:0]);
        end else begin
          extra_wr++;
        end
      end
      if (res_rd && sti_wr) viol++;
      if (sti_wr && prev_wr) viol++;
      if (!sti_wr && (sti_addr != prev_addr || sti_do != prev_do)) viol++;
      if (done && done_cyc < 0) done_cyc = cyc;
      prev_wr   = sti_wr;
      prev_addr = sti_addr;
      prev_do   = sti_do;
    end else begin
      prev_wr   = 1'b0;
      prev_addr = '0;
      prev_do   = '0;
    end
  end

  task automatic start_run(input int m, input logic [7:0] t);
    reset = 1'b0;
    mode  = m;
    thr   = t;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_res_rd", 32'(res_rd), 0);
    chk("rst_res_addr", 32'(res_addr), 0);
    chk("rst_sti_wr", 32'(sti_wr), 0);
    chk("rst_sti_addr", 32'(sti_addr), 0);
    chk("rst_sti_do", 32'(sti_do), 0);
    chk("rst_fg_cnt", 32'(fg_cnt), 0);
    chk("rst_done", 32'(done), 0);
    sb_q.delete();
    for (int w = 0; w < NW; w++) begin
      sb_q.push_back({w[9:0], exp_word(m, w, t)});
    end
    wr_cnt   = 0;
    extra_wr = 0;
    fg_exp   = 0;
    viol     = 0;
    done_cyc = -1;
    reset    = 1'b1;
  endtask

  task automatic wait_writes(input int n, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      #1;
      if (wr_cnt >= n) break;
    end
    chk("wr_cnt", 32'(wr_cnt), 32'(n));
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      #1;
      if (done) break;
    end
    chk("done_cyc", 32'(done_cyc), 32'(DONE_CYC));
  endtask

  task automatic end_checks();
    chk("fg_model", 32'(fg_cnt), 32'(fg_exp));
    chk("extra_wr", 32'(extra_wr), 0);
    chk("protocol", 32'(viol), 0);
  endtask

  initial begin
    // All-zero map, thr=1: every word zero, timing of done
    start_run(0, 8'd1);
    wait_done(DONE_CYC + 100);
    chk("a_writes", 32'(wr_cnt), 32'(NW));
    chk("a_fg", 32'(fg_cnt), 0);
    chk("a_sb_left", 32'(sb_q.size()), 0);
    end_checks();
    repeat (20) @(negedge clk);
    #1;
    chk("a_done_hold", 32'(done), 1);
    chk("a_rd_idle", 32'(res_rd), 0);
    chk("a_no_more_wr", 32'(wr_cnt), 32'(NW));

    // All-5 map, thr=0, reset mid-read of word 300
    start_run(1, 8'd0);
    wait_writes(300, 300 * 18 + 100);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (res_addr == {10'd300, 4'd6}) break;
    end
    chk("b_mid_addr", 32'(res_addr), 32'({10'd300, 4'd6}));
    chk("b_pre_rst_wr", 32'(wr_cnt), 300);
    chk("b_fg_pre", 32'(fg_cnt), 300 * 16);
    start_run(1, 8'd0);
    wait_done(DONE_CYC + 100);
    chk("b_writes", 32'(wr_cnt), 32'(NW));
    chk("b_fg", 32'(fg_cnt), 16384);
    chk("b_sb_left", 32'(sb_q.size()), 0);
    end_checks();

    // Single foreground pixel in word 7
    start_run(2, 8'd3);
    wait_writes(64, 64 * 18 + 100);
    chk("c_fg", 32'(fg_cnt), 1);
    end_checks();

    // Alternating 2/0 along each word, thr=2
    start_run(3, 8'd2);
    wait_writes(32, 32 * 18 + 100);
    chk("d_fg", 32'(fg_cnt), 32 * 8);
    end_checks();

    // thr changed after sampling must be ignored
    start_run(4, 8'd1);
    repeat (3) @(negedge clk);
    thr = 8'd255;
    wait_writes(64, 64 * 18 + 100);
    chk("e_fg", 32'(fg_cnt), 64 * 16);
    end_checks();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
